// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix keypad scanner with row debounce, optional auto-repeat
// and a show-ahead key-code FIFO drained by a valid/ready handshake.
module keypad_scan_fifo #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int SCAN_TICKS = 100000,
    parameter int DEBOUNCE_TICKS = 500000,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE = 100000,
    localparam int KW = $clog2(NUM_ROWS * NUM_COLS),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [KW-1:0]       key_code,
    output logic [CW-1:0]       key_count,
    output logic                overflow,
    output logic                multi_key
);
    localparam int COLW = $clog2(NUM_COLS);
    localparam int ROWW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
    localparam int SW = $clog2(SCAN_TICKS + 1);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int PW = $clog2(RMAX + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    // HELD starts one cycle after the confirming push, so the first repeat lands at REPEAT_DELAY-1
    localparam int FIRST_LIM = REPEAT_DELAY > 1 ? REPEAT_DELAY - 2 : 0;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t              state;
    logic [NUM_ROWS-1:0] rs_meta, rs, pat;
    logic [COLW-1:0]     col, kcol;
    logic [SW-1:0]       scan_cnt;
    logic [DW-1:0]       db_cnt;
    logic [PW-1:0]       rep_cnt;
    logic                rep_first;
    logic [ROWW-1:0]     row_idx;
    logic [KW-1:0]       code;
    logic                all_high, one_low, db_done, rep_fire, push;

    always_comb begin
        row_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (!pat[r]) row_idx = ROWW'(r);
    end

    assign all_high = &rs;
    assign one_low  = $onehot(~pat);
    assign code     = KW'(int'(row_idx) * NUM_COLS + int'(kcol));
    assign db_done  = db_cnt == DW'(DEBOUNCE_TICKS - 1);
    assign rep_fire = state == HELD && !all_high && REPEAT_DELAY != 0 &&
                      rep_cnt == (rep_first ? PW'(FIRST_LIM) : PW'(REPEAT_RATE - 1));
    assign push     = (state == DEBOUNCE && rs == pat && db_done && one_low) || rep_fire;
    assign col_out  = ~(NUM_COLS'(1) << col);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= SCAN;
            rs_meta   <= '1;
            rs        <= '1;
            pat       <= '1;
            col       <= '0;
            kcol      <= '0;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            multi_key <= 1'b0;
        end else begin
            rs_meta   <= row_in;
            rs        <= rs_meta;
            multi_key <= 1'b0;
            case (state)
                SCAN:
                    if (!all_high) begin
                        pat    <= rs;
                        kcol   <= col;
                        db_cnt <= '0;
                        state  <= DEBOUNCE;
                    end else if (scan_cnt == SW'(SCAN_TICKS - 1)) begin
                        scan_cnt <= '0;
                        col      <= col == COLW'(NUM_COLS - 1) ? '0 : col + 1'b1;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                DEBOUNCE:
                    if (rs != pat) begin
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end else if (db_done) begin
                        if (one_low) begin
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
                            state     <= HELD;
                        end else begin
                            multi_key <= 1'b1;
                            db_cnt    <= '0;
                            state     <= RELEASE;
                        end
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                HELD:
                    if (all_high) begin
                        db_cnt <= '0;
                        state  <= RELEASE;
                    end else if (rep_fire) begin
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else if (REPEAT_DELAY != 0) begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                RELEASE:
                    if (!all_high) begin
                        db_cnt <= '0;
                    end else if (db_done) begin
                        scan_cnt <= '0;
                        col      <= kcol;
                        state    <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                default: state <= SCAN;
            endcase
        end
    end

    logic [KW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, full, wr_en;

    assign pop       = key_valid && key_ready;
    assign full      = count == CW'(FIFO_DEPTH);
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en     = push && (!full || pop);
    assign key_valid = count != '0;
    assign key_count = count;
    assign key_code  = key_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= code;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(wr_en) - CW'(pop);
            overflow <= push && full && !pop;
        end
    end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: keypad matrix model driving two scanners (repeat off / repeat on),
// scoreboard of expected key codes popped and compared as the FIFO drains.
module tb_keypad_scan_fifo;
    logic        clk = 0;
    logic        nRST = 0;
    logic [15:0] keys_a = '0, keys_b = '0;
    logic [3:0]  row_a, row_b, col_a, col_b;
    logic        valid_a, valid_b, ready_a = 1, ready_b = 1;
    logic [3:0]  code_a, code_b;
    logic [2:0]  count_a, count_b;
    logic        ovf_a, ovf_b, multi_a, multi_b;

    int checks = 0, errors = 0;
    int pops_a = 0, ovf_n = 0, multi_n = 0, ovf_bn = 0, multi_bn = 0, cyc = 0;
    int exp_q[$];
    int rec_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_scan_fifo #(.NUM_ROWS(4), .NUM_COLS(4), .SCAN_TICKS(4), .DEBOUNCE_TICKS(8),
        .FIFO_DEPTH(4), .REPEAT_DELAY(0), .REPEAT_RATE(10)) dut (
        .clk(clk), .nRST(nRST), .row_in(row_a), .col_out(col_a), .key_valid(valid_a),
        .key_ready(ready_a), .key_code(code_a), .key_count(count_a), .overflow(ovf_a),
        .multi_key(multi_a));

    keypad_scan_fifo #(.NUM_ROWS(4), .NUM_COLS(4), .SCAN_TICKS(4), .DEBOUNCE_TICKS(8),
        .FIFO_DEPTH(4), .REPEAT_DELAY(20), .REPEAT_RATE(10)) dut_rep (
        .clk(clk), .nRST(nRST), .row_in(row_b), .col_out(col_b), .key_valid(valid_b),
        .key_ready(ready_b), .key_code(code_b), .key_count(count_b), .overflow(ovf_b),
        .multi_key(multi_b));

    // a row reads low when any pressed key on it sits in a column being driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_a[r] = ~|(keys_a[r*4 +: 4] & ~col_a);
            row_b[r] = ~|(keys_b[r*4 +: 4] & ~col_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (nRST) begin
            if (ovf_a) ovf_n++;
            if (multi_a) multi_n++;
            if (ovf_b) ovf_bn++;
            if (multi_b) multi_bn++;
            if (valid_a && ready_a) begin
                pops_a++;
                if (exp_q.size() == 0) check("pop_unexpected", 32'(code_a), 99);
                else check("pop_code", 32'(code_a), exp_q.pop_front());
            end
            if (valid_b) begin
                rec_b.push_back(cyc);
                check("rep_code", 32'(code_b), 0);
            end
        end
    end

    // returns at the first sample where column c has just become the driven one
    task automatic wait_col(input bit b, input int c);
        int n = 0;
        logic [3:0] cv;
        cv = b ? col_b : col_a;
        while (!cv[c] && n < 40) begin @(negedge clk); n++; cv = b ? col_b : col_a; end
        while (cv[c] && n < 40) begin @(negedge clk); n++; cv = b ? col_b : col_a; end
        check("wait_col", 32'(cv[c]), 0);
    endtask

    task automatic press(input int r, input int c, input bit expect_push);
        wait_col(0, c);
        keys_a[r*4+c] = 1'b1;
        if (expect_push) exp_q.push_back(r*4 + c);
        repeat (20) @(negedge clk);
        keys_a = '0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int p0, o0, m0, s;
        int exp6[6] = '{11, 30, 40, 50, 60, 70};
        logic [3:0] pat_seq[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_a), 32'(4'b1110));
        check("rst_valid", 32'(valid_a), 0);
        check("rst_code", 32'(code_a), 0);
        check("rst_count", 32'(count_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_multi", 32'(multi_a), 0);
        nRST = 1;
        for (int k = 0; k < 20; k++) begin
            check("scan_col", 32'(col_a), 32'(pat_seq[(k/4)%4]));
            check("scan_valid", 32'(valid_a), 0);
            @(negedge clk);
        end

        p0 = pops_a;
        press(1, 2, 1);
        check("t2_pops", pops_a - p0, 1);
        check("t2_queue", exp_q.size(), 0);
        check("t2_count", 32'(count_a), 0);

        p0 = pops_a;
        wait_col(0, 1);
        keys_a[1] = 1'b1;
        repeat (5) @(negedge clk);
        keys_a = '0;
        repeat (20) @(negedge clk);
        check("t3_bounce_pops", pops_a - p0, 0);
        check("t3_bounce_count", 32'(count_a), 0);
        press(0, 1, 1);
        check("t3_pops", pops_a - p0, 1);

        ready_a = 0;
        o0 = ovf_n;
        press(0, 0, 1);
        press(1, 1, 1);
        press(2, 2, 1);
        press(3, 3, 1);
        press(0, 3, 0);
        check("t4_count", 32'(count_a), 4);
        check("t4_ovf", ovf_n - o0, 1);
        check("t4_valid", 32'(valid_a), 1);
        check("t4_head", 32'(code_a), 0);
        ready_a = 1;
        repeat (8) @(negedge clk);
        check("t4_drained", exp_q.size(), 0);
        check("t4_count_end", 32'(count_a), 0);

        m0 = multi_n;
        p0 = pops_a;
        wait_col(0, 1);
        keys_a[1] = 1'b1;
        keys_a[9] = 1'b1;
        repeat (20) @(negedge clk);
        keys_a = '0;
        repeat (20) @(negedge clk);
        check("t5_multi", multi_n - m0, 1);
        check("t5_no_entry", pops_a - p0, 0);
        press(3, 1, 1);
        check("t5_single", pops_a - p0, 1);
        check("t5_queue", exp_q.size(), 0);

        rec_b.delete();
        wait_col(1, 0);
        s = cyc;
        keys_b[0] = 1'b1;
        repeat (75) @(negedge clk);
        check("t6_pushes", rec_b.size(), 6);
        for (int i = 0; i < 6; i++)
            check("t6_push_time", i < rec_b.size() ? rec_b[i] - s : -1, exp6[i]);
        check("t6_ovf", ovf_bn, 0);
        check("t6_multi", multi_bn, 0);
        #3 nRST = 0;
        #1;
        check("t6_rst_col", 32'(col_b), 32'(4'b1110));
        check("t6_rst_valid", 32'(valid_b), 0);
        check("t6_rst_code", 32'(code_b), 0);
        check("t6_rst_count", 32'(count_b), 0);
        check("t6_rst_ovf", 32'(ovf_b), 0);
        check("t6_rst_multi", 32'(multi_b), 0);
        keys_b = '0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
